pmic_rail_sequencer: RTL and testbench



---
 rtl/pmic_pkg.sv | 24 ++
 rtl/pmic_delay_timer.sv | 26 ++
 rtl/pmic_rail_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_pmic_rail_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmic_pkg.sv
// Shared types and constants for the PMIC rail sequencer.
package pmic_pkg;

    localparam int unsigned RAIL_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWR_UP,
        ST_ON,
        ST_PWR_DN,
        ST_FAULT
    } state_e;

    typedef enum logic {
        PH_WAIT_PG,
        PH_SETTLE
    } phase_e;

    localparam logic [1:0] FC_NONE       = 2'd0;
    localparam logic [1:0] FC_PG_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_PG_LOST    = 2'd2;
    localparam logic [1:0] FC_LOW_BAT    = 2'd3;

endpackage

// File: rtl/pmic_delay_timer.sv
// Saturating up-counter used for power-good timeout, settle and power-down gaps.
module pmic_delay_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    output logic [TMR_W-1:0] value
);

    logic [TMR_W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= '0;
        end else if (en && (value_q != '1)) begin
            value_q <= value_q + TMR_W'(1);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pmic_rail_sequencer.sv
// Sequences NUM_RAILS LDO enables up in order and down in reverse, with power-good supervision.
module pmic_rail_sequencer
    import pmic_pkg::*;
#(
    parameter int unsigned NUM_RAILS  = 3,
    parameter int unsigned TMR_W      = 16,
    parameter int unsigned RAMP_DLY   = 1000,
    parameter int unsigned PG_TIMEOUT = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  on_off,
    input  logic                  low_bat,
    input  logic                  low_pow,
    input  logic [NUM_RAILS-1:0]  rail_pg,
    output logic [NUM_RAILS-1:0]  rail_en,
    output logic                  mux_sel,
    output logic                  ready,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [RAIL_IDX_W-1:0] rail_idx
);

    if (NUM_RAILS < 1 || NUM_RAILS > 8 || TMR_W < 2 || TMR_W > 31 ||
        RAMP_DLY < 1 || 64'(RAMP_DLY) >= (64'd1 << TMR_W) ||
        PG_TIMEOUT <= RAMP_DLY || 64'(PG_TIMEOUT) >= (64'd1 << TMR_W)) begin : g_param_check
        $error("pmic_rail_sequencer: parameter out of range");
    end

    localparam logic [TMR_W-1:0]      SETTLE_LAST = TMR_W'(RAMP_DLY - 1);
    localparam logic [TMR_W-1:0]      PG_LAST     = TMR_W'(PG_TIMEOUT - 1);
    localparam logic [RAIL_IDX_W-1:0] LAST_IDX    = RAIL_IDX_W'(NUM_RAILS - 1);

    state_e                  state_q, state_d;
    phase_e                  phase_q, phase_d;
    logic [RAIL_IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_RAILS-1:0]    rail_en_q, rail_en_d;
    logic                    mux_q, mux_d;
    logic                    ready_q, ready_d;
    logic                    fault_q, fault_d;
    logic [1:0]              code_q, code_d;
    logic                    tmr_load, tmr_en;
    logic [TMR_W-1:0]        tmr_value;

    logic [NUM_RAILS-1:0]    cur_oh, nxt_oh, prv_oh, below, up_mask;
    logic                    pg_cur, pg_lost_up;

    pmic_delay_timer #(.TMR_W(TMR_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .value (tmr_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_OFF;
            phase_q   <= PH_WAIT_PG;
            idx_q     <= '0;
            rail_en_q <= '0;
            mux_q     <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            rail_en_q <= rail_en_d;
            mux_q     <= mux_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    // Rails already up: everything below idx, plus idx itself once its pg has been seen.
    always_comb begin
        cur_oh = '0;
        nxt_oh = '0;
        prv_oh = '0;
        below  = '0;
        for (int unsigned i = 0; i < NUM_RAILS; i++) begin
            cur_oh[i] = (i == 32'(idx_q));
            nxt_oh[i] = (i == 32'(idx_q) + 1);
            prv_oh[i] = (i + 1 == 32'(idx_q));
            below[i]  = (i < 32'(idx_q));
        end
        up_mask    = below | ((phase_q == PH_SETTLE) ? cur_oh : '0);
        pg_cur     = |(rail_pg & cur_oh);
        pg_lost_up = |(~rail_pg & up_mask);
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        rail_en_d = rail_en_q;
        ready_d   = ready_q;
        fault_d   = fault_q;
        code_d    = code_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                if (on_off && !low_bat) begin
                    state_d   = ST_PWR_UP;
                    phase_d   = PH_WAIT_PG;
                    idx_d     = '0;
                    rail_en_d = NUM_RAILS'(1);
                    tmr_load  = 1'b1;
                end else if (on_off) begin
                    code_d = FC_LOW_BAT;
                end else begin
                    code_d = FC_NONE;
                end
            end
            ST_PWR_UP: begin
                tmr_en = 1'b1;
                if (pg_lost_up) begin
                    state_d   = ST_FAULT;
                    rail_en_d = '0;
                    fault_d   = 1'b1;
                    ready_d   = 1'b0;
                    code_d    = FC_PG_LOST;
                end else if (phase_q == PH_WAIT_PG && !pg_cur && tmr_value == PG_LAST) begin
                    state_d   = ST_FAULT;
                    rail_en_d = '0;
                    fault_d   = 1'b1;
                    ready_d   = 1'b0;
                    code_d    = FC_PG_TIMEOUT;
                end else if (low_bat || !on_off) begin
                    state_d   = ST_PWR_DN;
                    rail_en_d = rail_en_q & ~cur_oh;
                    tmr_load  = 1'b1;
                    if (low_bat) begin
                        code_d = FC_LOW_BAT;
                    end
                end else if (phase_q == PH_WAIT_PG) begin
                    if (pg_cur) begin
                        phase_d  = PH_SETTLE;
                        tmr_load = 1'b1;
                    end
                end else if (tmr_value == SETTLE_LAST) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ON;
                        ready_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + RAIL_IDX_W'(1);
                        rail_en_d = rail_en_q | nxt_oh;
                        phase_d   = PH_WAIT_PG;
                        tmr_load  = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (|(~rail_pg)) begin
                    state_d   = ST_FAULT;
                    rail_en_d = '0;
                    fault_d   = 1'b1;
                    ready_d   = 1'b0;
                    code_d    = FC_PG_LOST;
                end else if (low_bat || !on_off) begin
                    state_d   = ST_PWR_DN;
                    rail_en_d = rail_en_q & ~cur_oh;
                    ready_d   = 1'b0;
                    tmr_load  = 1'b1;
                    if (low_bat) begin
                        code_d = FC_LOW_BAT;
                    end
                end
            end
            ST_PWR_DN: begin
                tmr_en = 1'b1;
                if (low_bat) begin
                    code_d = FC_LOW_BAT;
                end
                if (tmr_value == SETTLE_LAST) begin
                    if (idx_q != '0) begin
                        idx_d     = idx_q - RAIL_IDX_W'(1);
                        rail_en_d = rail_en_q & ~prv_oh;
                        tmr_load  = 1'b1;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
            end
            ST_FAULT: begin
                if (!on_off) begin
                    state_d = ST_OFF;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        mux_d = (state_d == ST_OFF) ? 1'b0 : low_pow;
    end

    always_comb begin
        rail_en    = rail_en_q;
        mux_sel    = mux_q;
        ready      = ready_q;
        fault      = fault_q;
        fault_code = code_q;
        rail_idx   = idx_q;
    end

endmodule

// File: tb/tb_pmic_rail_sequencer.sv
// Directed scoreboard bench: expectations are queued with a due cycle and checked when that cycle arrives.
module tb_pmic_rail_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       on_off;
    logic       low_bat;
    logic       low_pow;
    logic [2:0] rail_pg;
    logic [2:0] rail_en;
    logic       mux_sel;
    logic       ready;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] rail_idx;

    pmic_rail_sequencer #(
        .NUM_RAILS  (3),
        .TMR_W      (16),
        .RAMP_DLY   (10),
        .PG_TIMEOUT (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .on_off     (on_off),
        .low_bat    (low_bat),
        .low_pow    (low_pow),
        .rail_pg    (rail_pg),
        .rail_en    (rail_en),
        .mux_sel    (mux_sel),
        .ready      (ready),
        .fault      (fault),
        .fault_code (fault_code),
        .rail_idx   (rail_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        string       tag;
        bit          chk_idx;
        logic [10:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    // Load model: pg rises 3 cycles after its enable unless blocked or dropped.
    int unsigned pg_cnt[3];
    logic [2:0]  pg_block = '0;
    logic [2:0]  pg_drop  = '0;

    task automatic drive_pg();
        for (int i = 0; i < 3; i++) begin
            rail_pg[i] = (rail_en[i] === 1'b1) && (pg_cnt[i] >= 3) && !pg_block[i] && !pg_drop[i];
        end
    endtask

    task automatic expect_at(input int unsigned dly, input string tag, input int idx,
                             input logic [2:0] en, input logic rdy, input logic flt,
                             input logic [1:0] code, input logic mux);
        exp_t e;
        e.at      = cyc + dly;
        e.tag     = tag;
        e.chk_idx = (idx >= 0);
        e.exp     = {3'(idx), en, rdy, flt, code, mux};
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [10:0] obs;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].at == cyc) begin
                e = sb[i];
                sb.delete(i);
                obs = {rail_idx, rail_en, ready, fault, fault_code, mux_sel};
                if (!e.chk_idx) obs[10:8] = e.exp[10:8];
                vectors++;
                assert (obs === e.exp) else begin
                    miscompares++;
                    $error("FAIL %s @%0d: observed idx/en/rdy/flt/code/mux=%b expected %b",
                           e.tag, cyc, obs, e.exp);
                end
            end else begin
                i++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (rail_en[i] !== 1'b1) pg_cnt[i] = 0;
            else if (pg_cnt[i] < 1000) pg_cnt[i]++;
        end
        drive_pg();
    endtask

    task automatic run(input int unsigned n);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1; on_off = 1'b0; low_bat = 1'b0; low_pow = 1'b0; rail_pg = '0;
        for (int i = 0; i < 3; i++) pg_cnt[i] = 0;

        expect_at(1,  "reset_first", 0, 3'b000, 0, 0, 2'd0, 0);
        expect_at(10, "reset_hold",  0, 3'b000, 0, 0, 2'd0, 0);
        run(10);
        reset = 1'b0;

        // nominal power-up
        on_off = 1'b1;
        expect_at(1,  "up_rail0",   0, 3'b001, 0, 0, 2'd0, 0);
        expect_at(13, "up_r0_hold", 0, 3'b001, 0, 0, 2'd0, 0);
        expect_at(14, "up_rail1",   1, 3'b011, 0, 0, 2'd0, 0);
        expect_at(27, "up_rail2",   2, 3'b111, 0, 0, 2'd0, 0);
        expect_at(39, "up_notyet",  2, 3'b111, 0, 0, 2'd0, 0);
        expect_at(40, "up_ready",   2, 3'b111, 1, 0, 2'd0, 0);
        run(40);

        // graceful off; low_pow distinguishes PWR_DN from OFF
        on_off = 1'b0; low_pow = 1'b1;
        expect_at(1,  "dn_rail2", 2, 3'b011, 0, 0, 2'd0, 1);
        expect_at(10, "dn_gap",   2, 3'b011, 0, 0, 2'd0, 1);
        expect_at(11, "dn_rail1", 1, 3'b001, 0, 0, 2'd0, 1);
        expect_at(21, "dn_rail0", 0, 3'b000, 0, 0, 2'd0, 1);
        expect_at(30, "dn_last",  0, 3'b000, 0, 0, 2'd0, 1);
        expect_at(31, "dn_off",   0, 3'b000, 0, 0, 2'd0, 0);
        run(32);
        low_pow = 1'b0;

        // pg timeout on rail 1
        pg_block = 3'b010;
        on_off = 1'b1;
        expect_at(14, "to_rail1",   1, 3'b011, 0, 0, 2'd0, 0);
        expect_at(63, "to_before",  1, 3'b011, 0, 0, 2'd0, 0);
        expect_at(64, "to_fault",   1, 3'b000, 0, 1, 2'd1, 0);
        expect_at(70, "to_latched", 1, 3'b000, 0, 1, 2'd1, 0);
        run(70);
        pg_block = '0;
        on_off = 1'b0;
        expect_at(1, "to_clear", -1, 3'b000, 0, 0, 2'd0, 0);
        run(2);

        // pg lost while ON
        on_off = 1'b1;
        expect_at(40, "lost_ready", 2, 3'b111, 1, 0, 2'd0, 0);
        run(40);
        pg_drop = 3'b100;
        drive_pg();
        expect_at(1, "lost_fault", 2, 3'b000, 0, 1, 2'd2, 0);
        expect_at(4, "lost_held",  2, 3'b000, 0, 1, 2'd2, 0);
        tick();
        pg_drop = '0;
        drive_pg();
        run(3);
        on_off = 1'b0;
        expect_at(1, "lost_clear", -1, 3'b000, 0, 0, 2'd0, 0);
        run(2);

        // low_bat and on_off=0 together in ON
        on_off = 1'b1;
        expect_at(40, "lb_ready", 2, 3'b111, 1, 0, 2'd0, 0);
        run(40);
        low_bat = 1'b1; on_off = 1'b0;
        expect_at(1,  "lb_rail2",  2, 3'b011, 0, 0, 2'd3, 0);
        expect_at(11, "lb_rail1",  1, 3'b001, 0, 0, 2'd3, 0);
        expect_at(21, "lb_rail0",  0, 3'b000, 0, 0, 2'd3, 0);
        expect_at(31, "lb_offent", 0, 3'b000, 0, 0, 2'd3, 0);
        expect_at(32, "lb_offclr", 0, 3'b000, 0, 0, 2'd0, 0);
        run(32);
        on_off = 1'b1;
        expect_at(1, "lb_blocked", 0, 3'b000, 0, 0, 2'd3, 0);
        expect_at(3, "lb_stay",    0, 3'b000, 0, 0, 2'd3, 0);
        run(3);
        on_off = 1'b0;
        expect_at(1, "lb_release", 0, 3'b000, 0, 0, 2'd0, 0);
        run(1);
        low_bat = 1'b0;

        // abort while rail 1 waits for pg
        on_off = 1'b1;
        expect_at(14, "ab_rail1", 1, 3'b011, 0, 0, 2'd0, 0);
        run(15);
        on_off = 1'b0;
        expect_at(1,  "ab_r1off", 1, 3'b001, 0, 0, 2'd0, 0);
        expect_at(10, "ab_gap",   1, 3'b001, 0, 0, 2'd0, 0);
        expect_at(11, "ab_r0off", 0, 3'b000, 0, 0, 2'd0, 0);
        run(22);

        // reset mid power-up; mux_sel only follows low_pow outside OFF
        low_pow = 1'b1; on_off = 1'b1;
        expect_at(1,  "rs_rail0", 0, 3'b001, 0, 0, 2'd0, 1);
        expect_at(14, "rs_rail1", 1, 3'b011, 0, 0, 2'd0, 1);
        run(16);
        reset = 1'b1;
        expect_at(1, "rs_drop", 0, 3'b000, 0, 0, 2'd0, 0);
        run(2);
        reset = 1'b0; on_off = 1'b0;
        expect_at(3, "rs_off_mux", 0, 3'b000, 0, 0, 2'd0, 0);
        run(3);
        on_off = 1'b1;
        expect_at(1, "rs_reup", 0, 3'b001, 0, 0, 2'd0, 1);
        run(1);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
